// File: rtl/host_mem_bridge_if.sv
// Request/response bus between the UART host controller and host_mem_bridge,
// bundled with the bridge's on-chip memory port.
interface host_mem_bridge_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
);
   logic [AW-1:0] address;
   logic          wvalid;
   logic [DW-1:0] wdata;
   logic          wready;
   logic          rvalid;
   logic          rready;
   logic          rrvalid;
   logic [DW-1:0] rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic [DW-1:0] mem_rdata;

   // Handshake: a request is taken on the edge where wvalid&wready (or
   // rvalid&rready) is high; requesters hold valid and payload until then.
   modport slave (
      input  address, wvalid, wdata, rvalid, mem_gnt, mem_rdata,
      output wready, rready, rrvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output address, wvalid, wdata, rvalid, mem_gnt, mem_rdata,
      input  wready, rready, rrvalid, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/host_mem_bridge.sv
// Bus slave for the UART host: routes each access to a fixed-latency memory
// port or to a four-entry CSR page, with a grant timeout on the memory side.
module host_mem_bridge #(
   parameter int unsigned ADDR_BYTE   = 2,
   parameter int unsigned DATA_BYTE   = 2,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned ID_VALUE    = 32'h0000A5C3
) (
   input  logic             clk,
   input  logic             rst_n,
   host_mem_bridge_if.slave bus,
   output logic [1:0]       state_dbg_o
);
   localparam int unsigned   AW     = 8 * ADDR_BYTE;
   localparam int unsigned   DW     = 8 * DATA_BYTE;
   localparam logic [7:0]    TO_LIM = 8'(TIMEOUT);
   localparam logic [2:0]    LAT    = 3'(MEM_LATENCY);
   localparam logic [DW-1:0] ID_W   = DW'(ID_VALUE);

   typedef enum logic [1:0] {IDLE, REQ, RWAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [7:0]    tcnt_q, tcnt_d;
   logic [2:0]    lcnt_q, lcnt_d;
   logic [DW-1:0] resp_q, resp_d;
   logic [DW-1:0] scratch_q, scratch_d;
   logic [DW-1:0] err_q, err_d;
   logic          to_q, to_d;

   logic          csr_hit;
   logic [DW-1:0] csr_rdata;

   assign csr_hit = (addr_q[AW-1 -: 4] == 4'hF);

   always_comb begin
      csr_rdata = '0;
      case (addr_q[1:0])
         2'd0:    csr_rdata = ID_W;
         2'd1:    csr_rdata = scratch_q;
         2'd2:    csr_rdata = err_q;
         default: csr_rdata = DW'({(state_q != IDLE), to_q});
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      tcnt_d    = tcnt_q;
      lcnt_d    = lcnt_q;
      resp_d    = resp_q;
      scratch_d = scratch_q;
      err_d     = err_q;
      to_d      = to_q;
      case (state_q)
         IDLE: begin
            if (bus.wvalid || bus.rvalid) begin
               addr_d  = bus.address;
               wdata_d = bus.wdata;
               we_d    = bus.wvalid;
               tcnt_d  = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (csr_hit) begin
               if (we_q) begin
                  if (addr_q[1:0] == 2'd1) scratch_d = wdata_q;
                  state_d = IDLE;
               end else begin
                  resp_d  = csr_rdata;
                  state_d = RESP;
               end
            end else if (tcnt_q == TO_LIM) begin
               // mem_req is already low in this cycle, so a late grant cannot race the abort
               if (err_q != '1) err_d = err_q + DW'(1);
               to_d = 1'b1;
               if (we_q) begin
                  state_d = IDLE;
               end else begin
                  resp_d  = '1;
                  state_d = RESP;
               end
            end else if (bus.mem_gnt) begin
               if (we_q) begin
                  to_d    = 1'b0;
                  state_d = IDLE;
               end else begin
                  lcnt_d  = LAT;
                  state_d = RWAIT;
               end
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         RWAIT: begin
            if (lcnt_q == 3'd1) begin
               resp_d  = bus.mem_rdata;
               to_d    = 1'b0;
               state_d = RESP;
            end else begin
               lcnt_d = lcnt_q - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         tcnt_q    <= '0;
         lcnt_q    <= '0;
         resp_q    <= '0;
         scratch_q <= '0;
         err_q     <= '0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         tcnt_q    <= tcnt_d;
         lcnt_q    <= lcnt_d;
         resp_q    <= resp_d;
         scratch_q <= scratch_d;
         err_q     <= err_d;
         to_q      <= to_d;
      end
   end

   assign bus.wready    = (state_q == IDLE);
   assign bus.rready    = (state_q == IDLE) && !bus.wvalid;
   assign bus.rrvalid   = (state_q == RESP);
   assign bus.rdata     = resp_q;
   assign bus.mem_req   = (state_q == REQ) && !csr_hit && (tcnt_q != TO_LIM);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_host_mem_bridge.sv
// Directed and randomized checks of host_mem_bridge against a transaction-level
// model (latency formulas, CSR contents, memory image) kept in this bench.
module tb_host_mem_bridge;
  localparam int L  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  host_mem_bridge_if #(.AW(16), .DW(16)) bus_if ();

  host_mem_bridge #(
    .ADDR_BYTE(2), .DATA_BYTE(2), .MEM_LATENCY(L), .TIMEOUT(TO), .ID_VALUE(32'h0000A5C3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if),
    .state_dbg_o(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder
  bit gnt_on = 1'b1;
  int gnt_delay = 0;
  int req_age = 0;
  int pend = 0;
  int req_cycles = 0;
  logic [15:0] rd_val = 16'h0;
  logic [15:0] noise = 16'h0;
  logic [15:0] resp_mem[logic [15:0]];

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : (a ^ 16'h5A5A);
  endfunction

  assign bus_if.mem_gnt   = bus_if.mem_req && gnt_on && (req_age >= gnt_delay);
  assign bus_if.mem_rdata = (pend == 1) ? rd_val : noise;

  always @(posedge clk) begin
    noise <= 16'($urandom);
    if (bus_if.mem_req) req_age <= req_age + 1;
    else req_age <= 0;
    if (pend > 0) pend <= pend - 1;
    if (bus_if.mem_req && bus_if.mem_gnt) begin
      if (bus_if.mem_we) resp_mem[bus_if.mem_addr] = bus_if.mem_wdata;
      else begin
        rd_val <= mem_lookup(bus_if.mem_addr);
        pend   <= L;
      end
    end
  end

  always @(negedge clk) if (bus_if.mem_req) req_cycles++;

  // reference model
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] ref_scratch = 16'h0;
  logic [15:0] ref_err = 16'h0;
  bit ref_to = 1'b0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ref_lookup(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] csr_ref(input logic [1:0] sel);
    case (sel)
      2'd0:    return 16'hA5C3;
      2'd1:    return ref_scratch;
      2'd2:    return ref_err;
      default: return {14'b0, 1'b1, ref_to};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic accept(input bit is_write, input logic [15:0] a, input logic [15:0] d,
                        output int t0);
    bit rdy;
    bit done;
    done = 1'b0;
    t0 = -1;
    @(negedge clk);
    bus_if.address = a;
    bus_if.wdata   = d;
    bus_if.wvalid  = is_write;
    bus_if.rvalid  = !is_write;
    for (int k = 0; k < 100 && !done; k++) begin
      #1;
      rdy = is_write ? bus_if.wready : bus_if.rready;
      @(posedge clk);
      if (rdy) begin
        t0 = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    bus_if.wvalid = 1'b0;
    bus_if.rvalid = 1'b0;
    check("handshake", done, 1);
  endtask

  task automatic wait_resp(input int t0, output int lat, output logic [15:0] data);
    bit seen;
    seen = 1'b0;
    lat = -1;
    data = 16'hxxxx;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (bus_if.rrvalid) begin
        seen = 1'b1;
        lat  = cyc - t0;
        data = bus_if.rdata;
      end
    end
    check("rrvalid_seen", seen, 1);
    @(negedge clk);
    check("rrvalid_pulse", bus_if.rrvalid, 0);
    check("rdata_hold", bus_if.rdata, data);
  endtask

  task automatic wait_idle(input int t0, output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (bus_if.wready) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    check("idle_seen", seen, 1);
  endtask

  task automatic do_txn(input bit is_write, input logic [15:0] a, input logic [15:0] d,
                        input int delay, input bit never, output int lat, output logic [15:0] data);
    bit csr;
    bit timed_out;
    int exp_lat;
    int exp_req;
    int t0;
    logic [15:0] exp_data;
    csr = (a[15:12] == 4'hF);
    timed_out = !csr && (never || delay >= TO);
    gnt_on = !never;
    gnt_delay = delay;
    req_cycles = 0;
    exp_data = 16'hFFFF;
    if (csr) begin
      exp_req = 0;
      exp_lat = 2;
      if (is_write) begin
        if (a[1:0] == 2'd1) ref_scratch = d;
      end else begin
        exp_data = csr_ref(a[1:0]);
      end
    end else if (timed_out) begin
      exp_req = TO;
      exp_lat = TO + 2;
      if (ref_err != 16'hFFFF) ref_err++;
      ref_to = 1'b1;
    end else begin
      exp_req = delay + 1;
      exp_lat = is_write ? delay + 2 : delay + L + 2;
      ref_to = 1'b0;
      if (is_write) ref_mem[a] = d;
      else exp_data = ref_lookup(a);
    end
    if (!is_write) exp_q.push_back(exp_data);
    accept(is_write, a, d, t0);
    @(negedge clk);
    check("wready_busy", bus_if.wready, 0);
    check("mem_req_first", bus_if.mem_req, !csr);
    if (!csr) begin
      check("mem_we", bus_if.mem_we, is_write);
      check("mem_addr", bus_if.mem_addr, a);
      if (is_write) check("mem_wdata", bus_if.mem_wdata, d);
    end
    if (is_write) begin
      wait_idle(t0, lat);
      data = d;
    end else begin
      wait_resp(t0, lat, data);
      check($sformatf("rdata@%h", a), data, exp_q.pop_front());
    end
    check($sformatf("latency@%h", a), lat, exp_lat);
    check($sformatf("mem_req_cycles@%h", a), req_cycles, exp_req);
    if (is_write && !csr && !timed_out) check("mem_stored", mem_lookup(a), d);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int t0;
    int t1;
    int n_rr;
    int n_mr;
    bit done;
    bit rdy;
    bit is_w;
    bit never;
    int delay;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] data;

    bus_if.address = '0;
    bus_if.wdata   = '0;
    bus_if.wvalid  = 1'b0;
    bus_if.rvalid  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wready", bus_if.wready, 1);
    check("rst_rready", bus_if.rready, 1);
    check("rst_rrvalid", bus_if.rrvalid, 0);
    check("rst_rdata", bus_if.rdata, 0);
    check("rst_mem_req", bus_if.mem_req, 0);
    check("rst_mem_we", bus_if.mem_we, 0);
    check("rst_mem_addr", bus_if.mem_addr, 0);
    check("rst_mem_wdata", bus_if.mem_wdata, 0);
    bus_if.wvalid = 1'b1;
    #1;
    check("rst_rready_wvalid", bus_if.rready, 0);
    bus_if.wvalid = 1'b0;
    rst_n = 1'b1;

    // memory write, immediate grant
    do_txn(1, 16'h0010, 16'h1234, 0, 0, lat, data);
    check("wr_idle_at_2", lat, 2);

    // memory read, immediate then delayed grant
    resp_mem[16'h0020] = 16'hBEEF;
    ref_mem[16'h0020]  = 16'hBEEF;
    do_txn(0, 16'h0020, 16'h0, 0, 0, lat, data);
    check("rd_beef_data", data, 16'hBEEF);
    check("rd_beef_lat", lat, 4);
    do_txn(0, 16'h0020, 16'h0, 3, 0, lat, data);
    check("rd_delay3_lat", lat, 7);
    // grant on the last allowed cycle still counts
    do_txn(0, 16'h0020, 16'h0, TO - 1, 0, lat, data);
    check("rd_last_gnt_data", data, 16'hBEEF);

    // CSR page
    do_txn(0, 16'hF000, 16'h0, 0, 0, lat, data);
    check("csr_id", data, 16'hA5C3);
    do_txn(1, 16'hF001, 16'h5A5A, 0, 0, lat, data);
    do_txn(0, 16'hF001, 16'h0, 0, 0, lat, data);
    check("csr_scratch", data, 16'h5A5A);
    do_txn(0, 16'hF7A5, 16'h0, 0, 0, lat, data);
    check("csr_alias", data, 16'h5A5A);
    do_txn(1, 16'hF000, 16'h0000, 0, 0, lat, data);
    do_txn(0, 16'hF000, 16'h0, 0, 0, lat, data);
    check("csr_id_ro", data, 16'hA5C3);

    // timeout
    do_txn(0, 16'h0030, 16'h0, 0, 1, lat, data);
    check("to_data", data, 16'hFFFF);
    check("to_req_cycles", req_cycles, TO);
    do_txn(0, 16'hF002, 16'h0, 0, 0, lat, data);
    check("to_err_cnt", data, 16'h0001);
    do_txn(0, 16'hF003, 16'h0, 0, 0, lat, data);
    check("to_status", data, 16'h0003);
    do_txn(0, 16'h0020, 16'h0, 1, 0, lat, data);
    do_txn(0, 16'hF003, 16'h0, 0, 0, lat, data);
    check("status_cleared", data, 16'h0002);
    do_txn(1, 16'h0050, 16'h1111, 0, 1, lat, data);
    do_txn(0, 16'hF002, 16'h0, 0, 0, lat, data);
    check("to_err_cnt2", data, 16'h0002);

    // simultaneous write and read: write first, read on the next IDLE cycle
    gnt_on = 1'b1;
    gnt_delay = 0;
    @(negedge clk);
    bus_if.address = 16'h0040;
    bus_if.wdata   = 16'h7E57;
    bus_if.wvalid  = 1'b1;
    bus_if.rvalid  = 1'b1;
    #1;
    check("both_rready", bus_if.rready, 0);
    check("both_wready", bus_if.wready, 1);
    @(posedge clk);
    t0 = cyc;
    #1;
    bus_if.wvalid = 1'b0;
    ref_mem[16'h0040] = 16'h7E57;
    ref_to = 1'b0;
    done = 1'b0;
    t1 = -1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (k == 0) check("both_mem_we", bus_if.mem_we & bus_if.mem_req, 1);
      #1;
      rdy = bus_if.rready;
      @(posedge clk);
      if (rdy) begin
        t1 = cyc;
        done = 1'b1;
      end
    end
    #1;
    bus_if.rvalid = 1'b0;
    check("both_rd_gap", t1 - t0, 2);
    wait_resp(t1, lat, data);
    check("both_rd_data", data, 16'h7E57);
    check("both_rd_lat", lat, 4);

    // reset during RWAIT
    do_txn(1, 16'hF001, 16'h1357, 0, 0, lat, data);
    gnt_on = 1'b1;
    gnt_delay = 0;
    accept(0, 16'h0020, 16'h0, t0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_scratch = 16'h0;
    ref_err = 16'h0;
    ref_to = 1'b0;
    n_rr = 0;
    n_mr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_if.rrvalid) n_rr++;
      if (bus_if.mem_req) n_mr++;
    end
    check("rst_abort_rrvalid", n_rr, 0);
    check("rst_abort_mem_req", n_mr, 0);
    check("rst_abort_idle", bus_if.wready, 1);
    do_txn(0, 16'hF001, 16'h0, 0, 0, lat, data);
    check("rst_scratch", data, 16'h0);
    do_txn(0, 16'hF002, 16'h0, 0, 0, lat, data);
    check("rst_err_cnt", data, 16'h0);
    do_txn(0, 16'h0020, 16'h0, 0, 0, lat, data);
    check("rst_next_read", data, 16'hBEEF);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      is_w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = {4'hF, 12'($urandom)};
      else a = {4'($urandom_range(0, 14)), 12'($urandom)};
      d = 16'($urandom);
      delay = $urandom_range(0, 5);
      never = ($urandom_range(0, 9) == 0);
      do_txn(is_w, a, d, delay, never, lat, data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/host_mem_bridge.md
# host_mem_bridge

Bus-side slave for the UART host: consumes the `address`/`wvalid`/`wdata`/`rvalid` request bus driven by the UART host controller and produces its `wready`/`rready`/`rrvalid`/`rdata` responses. Each access goes either to an on-chip synchronous memory port with a fixed read latency, or to a small internal CSR page. A grant timeout keeps an unresponsive memory from hanging the host. Typical integration ties this block's `rst_n` to the host's `rst_n_out`, so host reset commands also clear the bridge.

## Interface
- `ADDR_BYTE`, 2: address width in bytes; AW = 8*ADDR_BYTE.
- `DATA_BYTE`, 2: data width in bytes; DW = 8*DATA_BYTE.
- `MEM_LATENCY`, 2: cycles from the `mem_gnt` cycle to valid `mem_rdata`; legal range 1..4.
- `TIMEOUT`, 255: maximum cycles in REQ without `mem_gnt`; legal range 1..255.
- `ID_VALUE`, 16'hA5C3: CSR 0 contents, zero-extended or truncated to DW.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `address`  in  AW  request address.
- `wvalid`  in  1  write request; held until handshake.
- `wdata`  in  DW  write data.
- `wready`  out  1  write accept.
- `rvalid`  in  1  read request; held until handshake.
- `rready`  out  1  read accept.
- `rrvalid`  out  1  read response; one-cycle pulse.
- `rdata`  out  DW  read response data; valid with `rrvalid`, held until the next response.
- `mem_req`  out  1  memory request; held until `mem_gnt` or timeout.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req` = 1.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_gnt`  in  1  memory accepted the request this cycle; sampled only while `mem_req` = 1.
- `mem_rdata`  in  DW  memory read data, valid MEM_LATENCY cycles after the grant cycle.

## Operation
- **Address decode.**
  - CSR hit: `address[AW-1 -: 4]` == 4'hF; the register is selected by `address[1:0]`, other bits are ignored (aliased).
  - Any other address is a memory access.
- **CSR map.**
  - 0: ID (RO) = ID_VALUE.
  - 1: SCRATCH (RW), reset 0.
  - 2: ERR_CNT (RO), saturating at all-ones, reset 0.
  - 3: STATUS (RO): bit0 = last memory access timed out; bit1 = busy (state != IDLE); other bits 0.
  - Writes to RO registers are accepted and discarded.
- **Ready.** `wready` = (state == IDLE). `rready` = (state == IDLE) & !wvalid. Write wins when both are requested.
- **FSM states:** IDLE, REQ, RWAIT, RESP.
- **IDLE:**
  - On a write or read handshake, latch address, wdata and type into internal registers, clear the timeout counter, go to REQ.
- **REQ, CSR hit:**
  - Write: update SCRATCH if selected, go to IDLE.
  - Read: load the selected CSR into the response register, go to RESP.
  - `mem_req` stays 0 for CSR accesses.
- **REQ, memory access:**
  - Drive `mem_req` = 1 with the latched `mem_we`/`mem_addr`/`mem_wdata`.
  - On `mem_gnt`:
    - write: go to IDLE, clear STATUS.bit0;
    - read: load the latency counter with MEM_LATENCY, go to RWAIT.
  - Without `mem_gnt`, increment the timeout counter.
  - If the counter reaches TIMEOUT without a grant:
    - drop `mem_req` on the next edge, increment ERR_CNT (saturating), set STATUS.bit0;
    - write: go to IDLE;
    - read: load all-ones into the response register, go to RESP.
- **RWAIT:**
  - Decrement the latency counter each cycle.
  - When it reaches 0, capture `mem_rdata`, clear STATUS.bit0, go to RESP.
- **RESP:**
  - `rrvalid` = 1 for exactly this one cycle; `rdata` = the response register.
  - Go to IDLE.
- **Reset** (at any time, including mid-access): state = IDLE, `mem_req` = 0, `rrvalid` = 0, `rdata` = 0, SCRATCH = 0, ERR_CNT = 0, STATUS.bit0 = 0. An aborted access produces no response.
- `mem_rdata` arriving after a timeout is ignored.

## Timing
- Values out of reset: `wready` = 1, `rready` = !wvalid, `rrvalid` = 0, `rdata` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Handshake at edge T0. REQ occupies the cycle after T0 (T0+1); `mem_req` is high from that cycle.
- Memory grant in the cycle ending at edge Tg: `mem_rdata` is sampled in the cycle ending at edge Tg+MEM_LATENCY. `rrvalid` is high in the cycle after that edge, i.e. edge Tg+MEM_LATENCY+1. With an immediate grant, `rrvalid` comes MEM_LATENCY+2 cycles after T0.
- CSR read: `rrvalid` 2 cycles after T0. CSR write: back in IDLE 2 cycles after T0.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles. A timed-out read gives `rrvalid` TIMEOUT+2 cycles after T0.
- A grant in the same cycle the counter reaches TIMEOUT counts as a grant (no timeout).
- `wready`/`rready` are low from T0+1 until the FSM returns to IDLE. There is no back-to-back acceptance.

## Test plan
- Memory write 0x0010 ← 0x1234, `mem_gnt` held 1 -> `mem_req`/`mem_we` = 1 for exactly 1 cycle at T0+1 with `mem_addr` = 0x0010 and `mem_wdata` = 0x1234; `wready` = 1 again at T0+2.
- Memory read 0x0020 with MEM_LATENCY = 2, model returns 0xBEEF -> single-cycle `rrvalid` with `rdata` = 0xBEEF, 4 cycles after T0. Repeat with `mem_gnt` delayed 3 cycles -> `rrvalid` 7 cycles after T0.
- CSR access -> read 0xF000 gives 0xA5C3 (`rrvalid` 2 cycles after T0); write 0xF001 ← 0x5A5A, then read 0xF001 gives 0x5A5A; write 0xF000 ← 0 leaves ID = 0xA5C3.
- TIMEOUT = 8, `mem_gnt` tied 0, read 0x0030 -> `mem_req` high for 8 cycles, then `rdata` = 0xFFFF with `rrvalid`; reading 0xF002 gives 1 and reading 0xF003 gives bit0 = 1; a following good read clears bit0.
- `wvalid` and `rvalid` asserted together -> `rready` = 0 and the write is performed first; the read is accepted on the next IDLE cycle.
- `rst_n` pulsed low during RWAIT -> no `rrvalid`, `mem_req` = 0, SCRATCH and ERR_CNT read back 0, next read completes normally.
